// File: rtl/axis_measure_pulse_mc_pkg.sv
// Shared types and field layout for the multi-channel pulse measurement block.
package axis_measure_pulse_mc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DELAY,
    ST_PRE_BASE,
    ST_RAMP_UP,
    ST_TOP,
    ST_RAMP_DOWN,
    ST_POST_BASE
  } state_e;

  localparam int CFG_THR_W  = 32;
  localparam int CFG_AVG_W  = 4;
  localparam int CFG_RSVD_W = 3;
  localparam int AVG_EXT_W  = 15;

  localparam int STS_CNT_W     = 16;
  localparam int STS_PULSE_LSB = 0;
  localparam int STS_DROP_LSB  = 16;

  function automatic int cfg_off_lsb(input int pw);   return 0;           endfunction
  function automatic int cfg_ramp_lsb(input int pw);  return pw;          endfunction
  function automatic int cfg_width_lsb(input int pw); return 2 * pw;      endfunction
  function automatic int cfg_thr_lsb(input int pw);   return 3 * pw;      endfunction
  function automatic int cfg_avg_lsb(input int pw);   return 3 * pw + 32; endfunction
  function automatic int cfg_trig_lsb(input int pw);  return 3 * pw + 36; endfunction
  function automatic int cfg_rsvd_lsb(input int pw);  return 3 * pw + 37; endfunction

  // First phase with a non-zero length; TOP always lasts at least one sample.
  function automatic state_e first_phase(input logic off_nz, input logic half_nz,
                                         input logic ramp_nz);
    if (off_nz)  return ST_DELAY;
    if (half_nz) return ST_PRE_BASE;
    if (ramp_nz) return ST_RAMP_UP;
    return ST_TOP;
  endfunction

endpackage

// File: rtl/axis_measure_pulse_lane.sv
// One channel: baseline/top accumulators, pulse averaging and the buffered result.
module axis_measure_pulse_lane
  import axis_measure_pulse_mc_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int ACC_WIDTH    = 32
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_i,
  input  logic                           add_base_i,
  input  logic                           add_top_i,
  input  logic                           pulse_end_i,
  input  logic                           avg_done_i,
  input  logic                           load_i,
  input  logic [CFG_AVG_W-1:0]           avg_log2_i,
  input  logic signed [CFG_THR_W-1:0]    threshold_i,
  output logic signed [ACC_WIDTH-1:0]    result_o,
  output logic                           over_o
);

  localparam int AVG_W = ACC_WIDTH + AVG_EXT_W;

  logic signed [ACC_WIDTH-1:0] base_q, top_q, result_q;
  logic signed [AVG_W-1:0]     avg_q;
  logic                        over_q;

  logic signed [ACC_WIDTH-1:0] sample_ext, base_sum, top_sum, diff, result_d;
  logic signed [AVG_W-1:0]     avg_sum, avg_shift;

  // The sample arriving on the pulse-end cycle is folded in before the difference.
  always_comb begin
    sample_ext = ACC_WIDTH'(sample_i);
    base_sum   = base_q + (add_base_i ? sample_ext : '0);
    top_sum    = top_q + (add_top_i ? sample_ext : '0);
    diff       = top_sum - base_sum;
    avg_sum    = avg_q + AVG_W'(diff);
    avg_shift  = avg_sum >>> avg_log2_i;
    result_d   = avg_shift[ACC_WIDTH-1:0];
  end

  logic unused_avg_hi;
  assign unused_avg_hi = ^avg_shift[AVG_W-1:ACC_WIDTH];

  always_ff @(posedge aclk) begin
    if (areset) begin
      base_q   <= '0;
      top_q    <= '0;
      avg_q    <= '0;
      result_q <= '0;
      over_q   <= 1'b0;
    end else begin
      if (pulse_end_i) begin
        base_q <= '0;
        top_q  <= '0;
        avg_q  <= avg_done_i ? '0 : avg_sum;
      end else begin
        base_q <= base_sum;
        top_q  <= top_sum;
      end
      if (load_i) begin
        result_q <= result_d;
        over_q   <= result_d < threshold_i;
      end
    end
  end

  assign result_o = result_q;
  assign over_o   = over_q;

endmodule

// File: rtl/axis_measure_pulse_mc.sv
// Multi-channel AXI-Stream pulse measurement: phase sequencer, averaging control
// and single-packet result buffer with drop counting.
module axis_measure_pulse_mc
  import axis_measure_pulse_mc_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int SAMPLE_WIDTH = 16,
  parameter int PULSE_WIDTH  = 16,
  parameter int ACC_WIDTH    = 32
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [3*PULSE_WIDTH+39:0]      cfg_data,
  input  logic                           trig,
  input  logic [NUM_CH*SAMPLE_WIDTH-1:0] s_axis_tdata,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  output logic [ACC_WIDTH-1:0]           m_axis_tdata,
  output logic                           m_axis_tvalid,
  output logic                           m_axis_tlast,
  input  logic                           m_axis_tready,
  output logic [NUM_CH-1:0]              overload,
  output logic [31:0]                    sts_data
);

  localparam int PW        = PULSE_WIDTH;
  localparam int IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int OFF_LSB   = cfg_off_lsb(PW);
  localparam int RAMP_LSB  = cfg_ramp_lsb(PW);
  localparam int WIDTH_LSB = cfg_width_lsb(PW);
  localparam int THR_LSB   = cfg_thr_lsb(PW);
  localparam int AVG_LSB   = cfg_avg_lsb(PW);
  localparam int TRIG_LSB  = cfg_trig_lsb(PW);
  localparam int RSVD_LSB  = cfg_rsvd_lsb(PW);

  state_e state_q, state_d, phase;
  logic [PW-1:0] cnt_q, cnt_d, phase_cnt, phase_len;

  logic [PW-1:0]                off_q, ramp_q, width_q;
  logic signed [CFG_THR_W-1:0]  thr_q;
  logic [CFG_AVG_W-1:0]         avg_log2_q;
  logic                         trig_mode_q;

  logic [PW-1:0]                off_in, ramp_in, width_in;
  logic [PW-1:0]                off_e, ramp_e, width_e, half_e;
  logic signed [CFG_THR_W-1:0]  thr_e;
  logic [CFG_AVG_W-1:0]         avg_log2_e;
  logic                         trig_mode_in, trig_mode_e;
  logic                         latch_cfg, add_base, add_top, pulse_end;

  logic [STS_CNT_W-1:0] pulse_cnt_q, dropped_q, avg_cnt_q;
  logic                 avg_done, load, out_valid_q;
  logic [IDX_W-1:0]     idx_q;
  logic [ACC_WIDTH-1:0] lane_result [NUM_CH];

  assign off_in       = cfg_data[OFF_LSB +: PW];
  assign ramp_in      = cfg_data[RAMP_LSB +: PW];
  assign width_in     = cfg_data[WIDTH_LSB +: PW];
  assign trig_mode_in = cfg_data[TRIG_LSB];

  logic unused_cfg_rsvd;
  assign unused_cfg_rsvd = ^cfg_data[RSVD_LSB +: CFG_RSVD_W];

  // In IDLE the live configuration drives the first sample; afterwards the latched copy.
  always_comb begin
    if (state_q == ST_IDLE) begin
      off_e       = off_in;
      ramp_e      = ramp_in;
      width_e     = width_in;
      thr_e       = cfg_data[THR_LSB +: CFG_THR_W];
      avg_log2_e  = cfg_data[AVG_LSB +: CFG_AVG_W];
      trig_mode_e = trig_mode_in;
    end else begin
      off_e       = off_q;
      ramp_e      = ramp_q;
      width_e     = width_q;
      thr_e       = thr_q;
      avg_log2_e  = avg_log2_q;
      trig_mode_e = trig_mode_q;
    end
    half_e = width_e >> 1;
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    phase     = state_q;
    phase_cnt = cnt_q;
    phase_len = '0;
    latch_cfg = 1'b0;
    add_base  = 1'b0;
    add_top   = 1'b0;
    pulse_end = 1'b0;

    if (state_q == ST_IDLE && (!trig_mode_e || (trig && s_axis_tvalid))) begin
      phase     = first_phase(off_e != '0, half_e != '0, ramp_e != '0);
      phase_cnt = '0;
      state_d   = phase;
      cnt_d     = '0;
      latch_cfg = 1'b1;
    end

    case (phase)
      ST_DELAY:                  phase_len = off_e;
      ST_PRE_BASE, ST_POST_BASE: phase_len = half_e;
      ST_RAMP_UP, ST_RAMP_DOWN:  phase_len = ramp_e;
      ST_TOP:                    phase_len = (width_e == '0) ? PW'(1) : width_e;
      default:                   phase_len = '0;
    endcase

    if (s_axis_tvalid && phase != ST_IDLE) begin
      add_base = (phase == ST_PRE_BASE) || (phase == ST_POST_BASE);
      add_top  = (phase == ST_TOP);
      if (phase_cnt == phase_len - 1'b1) begin
        cnt_d = '0;
        case (phase)
          ST_DELAY:     state_d = first_phase(1'b0, half_e != '0, ramp_e != '0);
          ST_PRE_BASE:  state_d = first_phase(1'b0, 1'b0, ramp_e != '0);
          ST_RAMP_UP:   state_d = ST_TOP;
          ST_TOP: begin
            if (ramp_e != '0)      state_d = ST_RAMP_DOWN;
            else if (half_e != '0) state_d = ST_POST_BASE;
            else                   pulse_end = 1'b1;
          end
          ST_RAMP_DOWN: begin
            if (half_e != '0) state_d = ST_POST_BASE;
            else              pulse_end = 1'b1;
          end
          default:      pulse_end = 1'b1;
        endcase
        if (pulse_end) begin
          if (trig_mode_e) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = first_phase(off_in != '0, (width_in >> 1) != '0, ramp_in != '0);
            latch_cfg = 1'b1;
          end
        end
      end else begin
        cnt_d = phase_cnt + 1'b1;
      end
    end
  end

  assign avg_done = pulse_end && (avg_cnt_q == STS_CNT_W'((1 << avg_log2_e) - 1));
  assign load     = avg_done && !out_valid_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      off_q       <= '0;
      ramp_q      <= '0;
      width_q     <= '0;
      thr_q       <= '0;
      avg_log2_q  <= '0;
      trig_mode_q <= 1'b0;
      pulse_cnt_q <= '0;
      dropped_q   <= '0;
      avg_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      idx_q       <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_cfg) begin
        off_q       <= off_in;
        ramp_q      <= ramp_in;
        width_q     <= width_in;
        thr_q       <= cfg_data[THR_LSB +: CFG_THR_W];
        avg_log2_q  <= cfg_data[AVG_LSB +: CFG_AVG_W];
        trig_mode_q <= trig_mode_in;
      end
      if (pulse_end) begin
        pulse_cnt_q <= pulse_cnt_q + 1'b1;
        avg_cnt_q   <= avg_done ? '0 : avg_cnt_q + 1'b1;
      end
      if (avg_done && out_valid_q && dropped_q != '1) dropped_q <= dropped_q + 1'b1;
      if (load) begin
        out_valid_q <= 1'b1;
      end else if (out_valid_q && m_axis_tready) begin
        if (idx_q == IDX_W'(NUM_CH - 1)) begin
          out_valid_q <= 1'b0;
          idx_q       <= '0;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    axis_measure_pulse_lane #(
      .SAMPLE_WIDTH(SAMPLE_WIDTH),
      .ACC_WIDTH   (ACC_WIDTH)
    ) u_lane (
      .aclk       (aclk),
      .areset     (areset),
      .sample_i   (s_axis_tdata[k*SAMPLE_WIDTH +: SAMPLE_WIDTH]),
      .add_base_i (add_base),
      .add_top_i  (add_top),
      .pulse_end_i(pulse_end),
      .avg_done_i (avg_done),
      .load_i     (load),
      .avg_log2_i (avg_log2_e),
      .threshold_i(thr_e),
      .result_o   (lane_result[k]),
      .over_o     (overload[k])
    );
  end

  assign s_axis_tready = 1'b1;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata  = out_valid_q ? lane_result[idx_q] : '0;
  assign m_axis_tlast  = out_valid_q && (idx_q == IDX_W'(NUM_CH - 1));
  assign sts_data[STS_PULSE_LSB +: STS_CNT_W] = pulse_cnt_q;
  assign sts_data[STS_DROP_LSB +: STS_CNT_W]  = dropped_q;

endmodule

// File: tb/tb_axis_measure_pulse_mc.sv
// Directed self-checking bench for axis_measure_pulse_mc (NUM_CH=2, 16-bit fields).
module tb_axis_measure_pulse_mc;

  localparam int CFG_W = 3 * 16 + 40;
  localparam int FILL  = 1000;

  logic             aclk = 1'b0;
  logic             areset;
  logic [CFG_W-1:0] cfg_data;
  logic             trig;
  logic [31:0]      s_axis_tdata;
  logic             s_axis_tvalid;
  logic             s_axis_tready;
  logic [31:0]      m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tlast;
  logic             m_axis_tready;
  logic [1:0]       overload;
  logic [31:0]      sts_data;

  axis_measure_pulse_mc #(
    .NUM_CH(2), .SAMPLE_WIDTH(16), .PULSE_WIDTH(16), .ACC_WIDTH(32)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .cfg_data     (cfg_data),
    .trig         (trig),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .overload     (overload),
    .sts_data     (sts_data)
  );

  always #5 aclk = ~aclk;

  int n_tests = 0;
  int n_fail  = 0;

  int   p_idx, p_len;
  bit   p_trig0, p_trigm;
  logic pre_last_valid;

  typedef struct {
    int         off, ramp, width;
    int         b0, t0, b1, t1;
    int         thr;
    int         exp0, exp1;
    logic [1:0] exp_ov;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
               name, $signed(act), act, $signed(exp), exp);
    end
  endtask

  function automatic logic [CFG_W-1:0] mk_cfg(input int off, input int ramp, input int width,
                                              input int thr, input int avg, input bit tm);
    logic [CFG_W-1:0] c;
    c        = '0;
    c[15:0]  = 16'(off);
    c[31:16] = 16'(ramp);
    c[47:32] = 16'(width);
    c[79:48] = 32'(thr);
    c[83:80] = 4'(avg);
    c[84]    = tm;
    return c;
  endfunction

  task automatic send(input int d0, input int d1, input bit tg);
    @(negedge aclk);
    s_axis_tdata  = {16'(d1), 16'(d0)};
    s_axis_tvalid = 1'b1;
    trig          = tg;
    @(posedge aclk);
    #1;
  endtask

  task automatic put(input int d0, input int d1);
    send(d0, d1, (p_idx == 0 && p_trig0) || (p_idx == 6 && p_trigm));
    if (p_idx == p_len - 2) pre_last_valid = m_axis_tvalid;
    p_idx++;
  endtask

  task automatic run_pulse(input int off, input int ramp, input int width,
                           input int b0, input int t0, input int b1, input int t1,
                           input bit trig0, input bit trigm);
    int half, top_n;
    half           = width / 2;
    top_n          = (width == 0) ? 1 : width;
    p_idx          = 0;
    p_len          = off + 2 * half + 2 * ramp + top_n;
    p_trig0        = trig0;
    p_trigm        = trigm;
    pre_last_valid = 1'b1;
    for (int j = 0; j < off; j++)   put(FILL, FILL);
    for (int j = 0; j < half; j++)  put(b0, b1);
    for (int j = 0; j < ramp; j++)  put(FILL, FILL);
    for (int j = 0; j < top_n; j++) put(t0, t1);
    for (int j = 0; j < ramp; j++)  put(FILL, FILL);
    for (int j = 0; j < half; j++)  put(b0, b1);
    s_axis_tvalid = 1'b0;
    trig          = 1'b0;
  endtask

  task automatic reset_dut(input logic [CFG_W-1:0] cfg);
    @(negedge aclk);
    areset        = 1'b1;
    cfg_data      = cfg;
    s_axis_tvalid = 1'b0;
    trig          = 1'b0;
    @(posedge aclk);
    @(posedge aclk);
    @(negedge aclk);
    areset = 1'b0;
  endtask

  // Called right after the edge that captured the final sample, with tready=1.
  task automatic expect_packet(input string name, input int e0, input int e1);
    check({name, " w0 valid"}, 32'(m_axis_tvalid), 32'd1);
    check({name, " w0 data"},  m_axis_tdata, 32'(e0));
    check({name, " w0 last"},  32'(m_axis_tlast), 32'd0);
    @(posedge aclk); #1;
    check({name, " w1 valid"}, 32'(m_axis_tvalid), 32'd1);
    check({name, " w1 data"},  m_axis_tdata, 32'(e1));
    check({name, " w1 last"},  32'(m_axis_tlast), 32'd1);
    @(posedge aclk); #1;
    check({name, " done"},     32'(m_axis_tvalid), 32'd0);
  endtask

  initial begin
    int         nw;
    logic [31:0] w [2];

    vecs[0] = '{off: 2, ramp: 1, width: 4, b0: 10,  t0: 110, b1: -5, t1: -55, thr: 0,
                exp0: 400,  exp1: -200, exp_ov: 2'b10};
    vecs[1] = '{off: 0, ramp: 0, width: 2, b0: 0,   t0: 200, b1: 25, t1: 150, thr: 300,
                exp0: 400,  exp1: 250,  exp_ov: 2'b10};
    vecs[2] = '{off: 1, ramp: 0, width: 0, b0: 0,   t0: 77,  b1: 0,  t1: -3,  thr: -10,
                exp0: 77,   exp1: -3,   exp_ov: 2'b00};
    vecs[3] = '{off: 0, ramp: 2, width: 1, b0: 0,   t0: 5,   b1: 0,  t1: 6,   thr: 6,
                exp0: 5,    exp1: 6,    exp_ov: 2'b01};
    vecs[4] = '{off: 3, ramp: 0, width: 5, b0: 100, t0: 0,   b1: -1, t1: 1,   thr: 0,
                exp0: -400, exp1: 9,    exp_ov: 2'b01};

    areset        = 1'b1;
    cfg_data      = mk_cfg(2, 1, 4, 0, 0, 0);
    trig          = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    check("reset tvalid",   32'(m_axis_tvalid), 32'd0);
    check("reset tlast",    32'(m_axis_tlast),  32'd0);
    check("reset tdata",    m_axis_tdata,       32'd0);
    check("reset overload", 32'(overload),      32'd0);
    check("reset sts",      sts_data,           32'd0);
    check("reset tready",   32'(s_axis_tready), 32'd1);

    for (int i = 0; i < 5; i++) begin
      reset_dut(mk_cfg(vecs[i].off, vecs[i].ramp, vecs[i].width, vecs[i].thr, 0, 1'b0));
      run_pulse(vecs[i].off, vecs[i].ramp, vecs[i].width,
                vecs[i].b0, vecs[i].t0, vecs[i].b1, vecs[i].t1, 1'b0, 1'b0);
      check($sformatf("v%0d early valid", i), 32'(pre_last_valid), 32'd0);
      expect_packet($sformatf("v%0d", i), vecs[i].exp0, vecs[i].exp1);
      check($sformatf("v%0d overload", i), 32'(overload), 32'(vecs[i].exp_ov));
      check($sformatf("v%0d sts", i), sts_data, 32'd1);
    end

    // Averaging over four pulses.
    reset_dut(mk_cfg(2, 1, 4, 0, 2, 1'b0));
    for (int p = 0; p < 4; p++) begin
      run_pulse(2, 1, 4, 10, 110 + p, -5, -55, 1'b0, 1'b0);
      if (p < 3) check($sformatf("avg no out p%0d", p), 32'(m_axis_tvalid), 32'd0);
    end
    expect_packet("avg", 406, -200);
    check("avg sts", sts_data, 32'd4);

    // Backpressure: second completion dropped, overload untouched.
    reset_dut(mk_cfg(2, 1, 4, 420, 0, 1'b0));
    m_axis_tready = 1'b0;
    run_pulse(2, 1, 4, 10, 110, -5, -55, 1'b0, 1'b0);
    check("bp p1 valid",    32'(m_axis_tvalid), 32'd1);
    check("bp p1 data",     m_axis_tdata,       32'd400);
    check("bp p1 overload", 32'(overload),      32'd3);
    run_pulse(2, 1, 4, 10, 120, -5, -45, 1'b0, 1'b0);
    check("bp hold valid",  32'(m_axis_tvalid), 32'd1);
    check("bp hold data",   m_axis_tdata,       32'd400);
    check("bp hold last",   32'(m_axis_tlast),  32'd0);
    check("bp sts",         sts_data,           {16'd1, 16'd2});
    check("bp overload",    32'(overload),      32'd3);
    m_axis_tready = 1'b1;
    nw = 0;
    w  = '{default: '0};
    for (int c = 0; c < 6; c++) begin
      if (m_axis_tvalid) begin
        if (nw < 2) w[nw] = m_axis_tdata;
        nw++;
      end
      @(posedge aclk); #1;
    end
    check("bp word count", 32'(nw), 32'd2);
    check("bp word0",      w[0],    32'd400);
    check("bp word1",      w[1],    32'(-200));

    // External trigger aligns the pulse; a mid-pulse trigger is ignored.
    reset_dut(mk_cfg(2, 1, 4, 0, 0, 1'b1));
    for (int j = 0; j < 20; j++) send(500, 500, 1'b0);
    run_pulse(2, 1, 4, 10, 110, -5, -55, 1'b1, 1'b1);
    expect_packet("trig", 400, -200);
    check("trig overload", 32'(overload), 32'd2);
    for (int j = 0; j < 12; j++) send(500, 500, 1'b0);
    s_axis_tvalid = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    check("trig idle valid", 32'(m_axis_tvalid), 32'd0);
    check("trig idle sts",   sts_data,           32'd1);

    // Reset in the middle of TOP abandons the pulse.
    @(negedge aclk);
    cfg_data = mk_cfg(2, 1, 4, 0, 0, 1'b0);
    send(FILL, FILL, 1'b0);
    send(FILL, FILL, 1'b0);
    send(10, -5, 1'b0);
    send(10, -5, 1'b0);
    send(FILL, FILL, 1'b0);
    send(110, -55, 1'b0);
    send(110, -55, 1'b0);
    @(negedge aclk);
    areset        = 1'b1;
    s_axis_tvalid = 1'b0;
    @(posedge aclk); #1;
    check("mid rst valid",    32'(m_axis_tvalid), 32'd0);
    check("mid rst tdata",    m_axis_tdata,       32'd0);
    check("mid rst tlast",    32'(m_axis_tlast),  32'd0);
    check("mid rst overload", 32'(overload),      32'd0);
    check("mid rst sts",      sts_data,           32'd0);
    @(posedge aclk);
    @(negedge aclk);
    areset = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check("post rst quiet", 32'(m_axis_tvalid), 32'd0);
    run_pulse(2, 1, 4, 10, 110, -5, -55, 1'b0, 1'b0);
    expect_packet("post rst", 400, -200);
    check("post rst sts", sts_data, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_measure_pulse_mc.md
# axis_measure_pulse_mc

Multi-channel, parametrised successor of the single-channel pulse measurement block. It sits on the ADC AXI-Stream path and slices a packed NUM_CH-channel sample stream into pulse periods: start delay, pre-baseline, ramp-up, pulse top, ramp-down, post-baseline. Per channel it forms (top sum − baseline sum), averages over 2^avg_log2 pulses and emits one NUM_CH-word AXI-Stream packet per average. Added over the previous generation: channel count, external trigger mode, averaging, a result buffer with drop counting, and per-channel overload flags.

## Interface
- NUM_CH, 2: channels packed in s_axis_tdata, 1..8.
- SAMPLE_WIDTH, 16: signed sample width per channel.
- PULSE_WIDTH, 16: width of the timing fields in cfg_data.
- ACC_WIDTH, 32: signed result width; also the m_axis_tdata width.
- aclk  in  1  sole clock.
- areset  in  1  reset; synchronous and active-high.
- cfg_data  in  3*PULSE_WIDTH+40  fields, LSB first:
  - offset_start [PW]
  - ramp [PW]
  - width [PW]
  - threshold [32, signed]
  - avg_log2 [4]
  - trig_mode [1]
  - reserved [3]
- trig  in  1  external trigger, sampled only while trig_mode=1.
- s_axis_tdata  in  NUM_CH*SAMPLE_WIDTH  channel k at [k*SAMPLE_WIDTH +: SAMPLE_WIDTH].
- s_axis_tvalid  in  1  sample strobe.
- s_axis_tready  out  1  constant 1.
- m_axis_tdata  out  ACC_WIDTH  result word for the current channel, channel 0 first.
- m_axis_tvalid  out  1  result word valid.
- m_axis_tlast  out  1  high on the word for channel NUM_CH-1.
- m_axis_tready  in  1  downstream ready.
- overload  out  NUM_CH  per-channel flag: last result < threshold (signed compare).
- sts_data  out  32  {dropped_cnt[15:0], pulse_cnt[15:0]}.

## Operation
- States: IDLE, DELAY, PRE_BASE, RAMP_UP, TOP, RAMP_DOWN, POST_BASE.
- Phase lengths, counted in accepted samples (s_axis_tvalid=1):
  - DELAY = offset_start
  - PRE_BASE = POST_BASE = width>>1
  - RAMP_UP = RAMP_DOWN = ramp
  - TOP = width
- A phase of length 0 is skipped in the same cycle the preceding phase ends. width=0 means TOP is a single sample.
- IDLE:
  - trig_mode=0: leaves immediately.
  - trig_mode=1: waits for trig=1 coincident with s_axis_tvalid=1. That sample counts as DELAY sample 0, or as the first sample of the first non-skipped phase.
- Config: all cfg fields are latched on leaving IDLE. Changes during a pulse take effect at the next pulse.
- Per channel: base_acc sums PRE_BASE and POST_BASE samples; top_acc sums TOP samples. All sign-extended to ACC_WIDTH, wrapping modulo 2^ACC_WIDTH.
- On the final POST_BASE sample, per channel:
  - diff = top_acc − base_acc
  - avg_acc (ACC_WIDTH+15 bits) += diff
  - base_acc and top_acc are cleared
  - pulse_cnt increments, wrapping at 16 bits
- Then go to IDLE (trig_mode=1) or DELAY (trig_mode=0).
- After 2^avg_log2 pulses the average completes:
  - result[k] = avg_acc[k] >>> avg_log2 (arithmetic shift), truncated to ACC_WIDTH.
  - avg_acc is cleared.
- Output buffer, one entry of NUM_CH words:
  - If the buffer is empty, results load into it; overload[k] updates from result[k] in the same cycle.
  - If the buffer is still draining, the new result is discarded, overload is unchanged, and dropped_cnt increments (saturates at 0xFFFF).
- Output handshake:
  - m_axis_tvalid stays high until all NUM_CH words have transferred.
  - The word index advances on tvalid&tready. tdata and tlast are held stable while tready=0.
- Reset: state IDLE; all accumulators, counters, buffer and word index cleared. Outputs read m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, overload=0, sts_data=0, s_axis_tready=1. A reset mid-pulse or mid-packet abandons it with no partial output.

## Timing
- Samples per pulse = offset_start + 2*(width>>1) + 2*ramp + max(width,1).
- Latency: m_axis_tvalid rises on the clock edge after the final POST_BASE sample of a completing average. Word 0 is presented in that cycle.
- Back-to-back: with m_axis_tready=1, a packet takes NUM_CH cycles. The buffer frees on the cycle after the last-word handshake, so a completion in that same cycle is dropped.
- trig is ignored outside IDLE and while trig_mode=0.

## Structure
- Package axis_measure_pulse_mc_pkg holds:
  - the state enum
  - cfg_data field offsets and widths
  - the sts_data field layout
- Sub-module axis_measure_pulse_lane, instantiated NUM_CH times: per-channel base/top/average accumulators and the result register. Control state machine, counters and output mux stay in the top module.

## Test plan
- NUM_CH=2, offset_start=2, ramp=1, width=4, avg_log2=0, trig_mode=0:
  - ch0 base 10, top 110; ch1 base −5, top −55; 12 samples per pulse.
  - Expect packet {400, −200}, tlast on word 1, tvalid one cycle after sample 12, pulse_cnt=1.
- avg_log2=2: ch0 per-pulse diffs 400, 404, 408, 412 -> single packet with ch0=406; no output after pulses 1–3.
- Backpressure:
  - m_axis_tready=0 across two completions -> first packet held stable, second dropped, dropped_cnt=1.
  - tready=1 afterwards -> exactly 2 words.
- trig_mode=1: stream idle samples, pulse trig at sample 20 -> accumulation aligned to sample 20. trig asserted mid-pulse is ignored.
- threshold=300 with result 250 on ch1 and 400 on ch0 -> overload=2'b10, updated only on buffer load.
- Assert areset during TOP, then release -> no output, sts_data=0, next pulse measures correctly from the first sample.
